// File: rtl/ahb_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_uart_rx_pkg
//  Description : Shared definitions for the AHB UART receiver: register word
//                offsets, STATUS/CLEAR bit positions, RX FSM state encodings
//                and the default baud divider.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_uart_rx_pkg;

  // HCLK cycles per UART bit at 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_CLK_DIV = 434;

  // Register offsets, as the word index HADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;  // 0x0
  localparam logic [1:0] REG_STATUS = 2'd1;  // 0x4
  localparam logic [1:0] REG_CLEAR  = 2'd2;  // 0x8

  // STATUS bit positions
  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;

  // CLEAR bit positions (sticky clears share the STATUS positions)
  localparam int CLR_FLUSH     = 0;
  localparam int CLR_OVERRUN   = ST_OVERRUN;
  localparam int CLR_FRAME_ERR = ST_FRAME_ERR;
  localparam int CLR_PARITY    = ST_PARITY_ERR;

  // Receiver FSM encodings
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_uart_rx_if
//  Description : AHB-Lite slave bus bundle for the UART receiver.
//  Signals     : HADDR[31:0], HSEL, HTRANS[1:0], HWRITE, HWDATA[31:0]
//                (master -> slave); HRDATA[31:0], HREADY, HRESP
//                (slave -> master).
//  Modports    : master, slave
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_uart_rx_if;
  logic [31:0] HADDR;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HSEL, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HSEL, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface
`default_nettype wire

// File: rtl/ahb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Byte FIFO for received characters. Flush has priority over
//                push/pop; a push into a full FIFO is accepted only when a pop
//                happens in the same cycle.
//  Ports       : clk_i, rst_ni (async active-low), push_i, pop_i, flush_i,
//                din_i[7:0], dout_o[7:0] (head), full_o, empty_o,
//                count_o[$clog2(DEPTH):0]
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_ni,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic                     flush_i,
  input  wire logic [7:0]               din_i,
  output logic      [7:0]               dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          w_do_push, w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through count_q.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/ahb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_uart_rx
//  Description : AHB-Lite slave UART receiver (8 data bits, 1 stop bit) with a
//                receive FIFO and sticky overrun / framing / parity flags.
//                Optional even-parity bit enabled by AHB_UART_RX_PARITY_EN.
//  Parameters  : CLK_DIV (HCLK cycles per bit), FIFO_DEPTH (power of 2, 2..64)
//  Ports       : HCLK, HRESETn (async active-low), ahb (AHB slave modport),
//                UART_RX (asynchronous serial input, idle high)
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_uart_rx
  import ahb_uart_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  wire logic        HCLK,
  input  wire logic        HRESETn,
  ahb_uart_rx_if.slave     ahb,
  input  wire logic        UART_RX
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);

  // --------------------------------------------------------------------------
  // Input synchronizer; prev_q extends it by one stage for edge detection.
  // --------------------------------------------------------------------------
  logic sync1_q, sync2_q, prev_q;
  logic w_rx, w_fall;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_rx   = sync2_q;
  assign w_fall = prev_q & ~sync2_q;

  // --------------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------------
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             par_bad_q;
  logic             w_tick;
  logic             w_load_half, w_load_full, w_shift, w_par_sample;
  logic             w_push, w_set_frame, w_par_mismatch;

  assign w_tick         = (cnt_q == '0);
  assign w_par_mismatch = (^shift_q) ^ w_rx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (w_fall) state_d = S_START;
      S_START:     if (w_tick) state_d = w_rx ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_tick && bit_q == 3'd7) begin
`ifdef AHB_UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef AHB_UART_RX_PARITY_EN
      S_PARITY:    if (w_tick) state_d = S_STOP;
`endif
      // A low stop bit parks the FSM until the line returns high, so a
      // stuck-low line cannot be mistaken for a stream of start bits.
      S_STOP:      if (w_tick) state_d = w_rx ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_shift      = 1'b0;
    w_par_sample = 1'b0;
    w_push       = 1'b0;
    w_set_frame  = 1'b0;
    case (state_q)
      S_IDLE:  w_load_half = w_fall;
      S_START: w_load_full = w_tick & ~w_rx;
      S_DATA: begin
        w_shift     = w_tick;
        w_load_full = w_tick;
      end
`ifdef AHB_UART_RX_PARITY_EN
      S_PARITY: begin
        w_par_sample = w_tick;
        w_load_full  = w_tick;
      end
`endif
      S_STOP: begin
        w_push      = w_tick & w_rx & ~par_bad_q;
        w_set_frame = w_tick & ~w_rx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      if (w_load_half)      cnt_q <= HALF_BIT;
      else if (w_load_full) cnt_q <= FULL_BIT;
      else if (!w_tick)     cnt_q <= cnt_q - CNT_W'(1);

      if (w_load_half)  bit_q <= '0;
      else if (w_shift) bit_q <= bit_q + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (w_shift) shift_q <= {w_rx, shift_q[7:1]};

      if (w_load_half)       par_bad_q <= 1'b0;
      else if (w_par_sample) par_bad_q <= w_par_mismatch;
    end
  end

  // --------------------------------------------------------------------------
  // AHB address phase capture
  // --------------------------------------------------------------------------
  logic       dp_valid_q, dp_write_q;
  logic [1:0] dp_addr_q;
  logic       w_accept, w_rd, w_wr, w_pop, w_clr_wr, w_flush;

  assign w_accept = ahb.HSEL & ahb.HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else begin
      dp_valid_q <= w_accept;
      dp_write_q <= w_accept & ahb.HWRITE;
      dp_addr_q  <= w_accept ? ahb.HADDR[3:2] : 2'd0;
    end
  end

  assign w_rd     = dp_valid_q & ~dp_write_q;
  assign w_wr     = dp_valid_q &  dp_write_q;
  assign w_clr_wr = w_wr & (dp_addr_q == REG_CLEAR);
  assign w_flush  = w_clr_wr & ahb.HWDATA[CLR_FLUSH];

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]                    fifo_head;
  logic                          fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  assign w_pop = w_rd & (dp_addr_q == REG_DATA) & ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .din_i   (shift_q),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Sticky error flags; a new event in the clearing cycle wins.
  // --------------------------------------------------------------------------
  logic overrun_q, frame_err_q, parity_err_q;
  logic w_set_ovr;

  // A pop in the same cycle makes room, so full+pop+push is not an overrun.
  assign w_set_ovr = w_push & fifo_full & ~w_pop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= (overrun_q & ~(w_clr_wr & ahb.HWDATA[CLR_OVERRUN])) | w_set_ovr;
      frame_err_q <= (frame_err_q & ~(w_clr_wr & ahb.HWDATA[CLR_FRAME_ERR])) | w_set_frame;
    end
  end

`ifdef AHB_UART_RX_PARITY_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) parity_err_q <= 1'b0;
    else parity_err_q <= (parity_err_q & ~(w_clr_wr & ahb.HWDATA[CLR_PARITY]))
                         | (w_par_sample & w_par_mismatch);
  end
`else
  assign parity_err_q = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read data
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (dp_addr_q)
        REG_DATA:   if (!fifo_empty) w_rdata[7:0] = fifo_head;
        REG_STATUS: begin
          w_rdata[ST_NOT_EMPTY]  = ~fifo_empty;
          w_rdata[ST_FULL]       = fifo_full;
          w_rdata[ST_OVERRUN]    = overrun_q;
          w_rdata[ST_FRAME_ERR]  = frame_err_q;
          w_rdata[ST_PARITY_ERR] = parity_err_q;
        end
        default: ;
      endcase
    end
  end

  assign ahb.HRDATA = w_rdata;
  assign ahb.HREADY = 1'b1;
  assign ahb.HRESP  = 1'b0;

  // Bus bits outside the decoded register map
  logic unused_ok;
  assign unused_ok = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0],
                       ahb.HWDATA[31:5], ahb.HWDATA[4], ahb.HWDATA[1], fifo_count};
endmodule
`default_nettype wire

// File: tb/tb_ahb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_uart_rx
//  Description : Directed bench for ahb_uart_rx (CLK_DIV=16, FIFO_DEPTH=8).
//                Received bytes are predicted into a scoreboard queue when a
//                frame is driven and checked when DATA is read back.
//                Parity scenario is active when AHB_UART_RX_PARITY_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_uart_rx;
  import ahb_uart_rx_pkg::*;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 8;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic uart_rx = 1'b1;

  ahb_uart_rx_if bus ();

  ahb_uart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus.slave),
    .UART_RX (uart_rx)
  );

  always #5 HCLK = ~HCLK;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb_q[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Drive one frame: start, 8 data bits LSB first, [parity], stop, then idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    uart_rx = 1'b0;
    idle(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CLK_DIV);
    end
`ifdef AHB_UART_RX_PARITY_EN
    uart_rx = par_bit;
    idle(CLK_DIV);
`else
    if (par_bit === 1'bx) uart_rx = 1'b1;
`endif
    uart_rx = stop_bit;
    idle(CLK_DIV);
    uart_rx = 1'b1;
    idle(CLK_DIV);
  endtask

  // Well-formed frame; the model keeps it only if the FIFO has room.
  task automatic send_good(input logic [7:0] b);
    if (sb_q.size() < FIFO_DEPTH) sb_q.push_back(b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HADDR  = addr;
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    data = bus.HRDATA;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HADDR  = addr;
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HWDATA = data;
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    HRESETn = 1'b0;
    idle(3);
    total++;
    if (bus.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want %h", bus.HRDATA, 32'h0); end
    total++;
    if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      bad++; $display("FAIL reset_resp: got hready=%b hresp=%b want 1/0", bus.HREADY, bus.HRESP);
    end
    HRESETn = 1'b1;
    idle(2);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic [7:0]  exp;
    send_good(8'hA5);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL single_status: got %h want %h", rd, 32'h1); end
    ahb_read(32'h0, rd);
    exp = sb_q.pop_front();
    total++;
    if (rd !== {24'h0, exp}) begin bad++; $display("FAIL single_data: got %h want %h", rd, {24'h0, exp}); end
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL single_status_after: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    logic [7:0]  exp;
    for (int b = 1; b <= 9; b++) send_good(8'(b));
    // Full FIFO: not_empty, full and overrun all set.
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h7) begin bad++; $display("FAIL ovr_status: got %h want %h", rd, 32'h7); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      ahb_read(32'h0, rd);
      exp = sb_q.pop_front();
      total++;
      if (rd !== {24'h0, exp}) begin bad++; $display("FAIL ovr_data[%0d]: got %h want %h", i, rd, {24'h0, exp}); end
    end
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h4) begin bad++; $display("FAIL ovr_sticky: got %h want %h", rd, 32'h4); end
    ahb_write(32'h8, 32'h4);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL ovr_clear: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_frame_err();
    logic [31:0] rd;
    send_frame(8'h55, 1'b0, ^8'h55);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h8) begin bad++; $display("FAIL ferr_status: got %h want %h", rd, 32'h8); end
    ahb_read(32'h0, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL ferr_data: got %h want %h", rd, 32'h0); end
    ahb_write(32'h8, 32'h8);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL ferr_clear: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    uart_rx = 1'b0;
    idle(CLK_DIV / 4);
    uart_rx = 1'b1;
    idle(2 * CLK_DIV);
    total++;
    if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL glitch_state: got %0d want %0d", dut.state_q, S_IDLE); end
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL glitch_status: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    send_good(8'h5A);
    send_good(8'hC3);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL flush_status_pre: got %h want %h", rd, 32'h1); end
    ahb_write(32'h8, 32'h1);
    sb_q.delete();
    ahb_read(32'h0, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL flush_data: got %h want %h", rd, 32'h0); end
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL flush_status: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    logic [7:0]  exp;
    logic [7:0]  partial;
    partial = 8'h96;
    uart_rx = 1'b0;
    idle(CLK_DIV);
    for (int i = 0; i < 4; i++) begin
      uart_rx = partial[i];
      idle(CLK_DIV);
    end
    HRESETn = 1'b0;
    uart_rx = 1'b1;
    idle(3);
    HRESETn = 1'b1;
    idle(CLK_DIV);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_status: got %h want %h", rd, 32'h0); end
    send_good(8'h3C);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL rstmid_status2: got %h want %h", rd, 32'h1); end
    ahb_read(32'h0, rd);
    exp = sb_q.pop_front();
    total++;
    if (rd !== {24'h0, exp}) begin bad++; $display("FAIL rstmid_data: got %h want %h", rd, {24'h0, exp}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  exp;
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    for (int i = 0; i < 3; i++) begin
      ahb_read(32'h0, rd);
      exp = sb_q.pop_front();
      total++;
      if (rd !== {24'h0, exp}) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd, {24'h0, exp}); end
    end
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL b2b_status: got %h want %h", rd, 32'h0); end
    ahb_read(32'hC, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want %h", rd, 32'h0); end
  endtask

`ifdef AHB_UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] rd;
    logic [7:0]  exp;
    send_frame(8'h07, 1'b1, 1'b0);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL par_status: got %h want %h", rd, 32'h10); end
    ahb_write(32'h8, 32'h10);
    ahb_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL par_clear: got %h want %h", rd, 32'h0); end
    sb_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    ahb_read(32'h0, rd);
    exp = sb_q.pop_front();
    total++;
    if (rd !== {24'h0, exp}) begin bad++; $display("FAIL par_data: got %h want %h", rd, {24'h0, exp}); end
  endtask
`endif

  initial begin
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HWDATA = 32'h0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_flush();
    test_reset_midframe();
    test_back_to_back();
`ifdef AHB_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
